// File: rtl/obi_rr_arbiter_if.sv
// Bundled manager-side and subordinate-side OBI signals for the round-robin arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface obi_rr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_W = DATA_WIDTH / 8;

    logic [NUM_REQ-1:0]            m_req_i;
    logic [NUM_REQ-1:0]            m_gnt_o;
    logic [NUM_REQ-1:0]            m_we_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] m_addr_i;
    logic [NUM_REQ*BE_W-1:0]       m_be_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] m_wdata_i;
    logic [NUM_REQ-1:0]            m_rvalid_o;
    logic [NUM_REQ-1:0]            m_rready_i;
    logic [DATA_WIDTH-1:0]         m_rdata_o;
    logic                          m_err_o;

    logic                          s_req_o;
    logic                          s_gnt_i;
    logic                          s_we_o;
    logic [ADDR_WIDTH-1:0]         s_addr_o;
    logic [BE_W-1:0]               s_be_o;
    logic [DATA_WIDTH-1:0]         s_wdata_o;
    logic                          s_rvalid_i;
    logic                          s_rready_o;
    logic [DATA_WIDTH-1:0]         s_rdata_i;
    logic                          s_err_i;

    modport slave (
        input  m_req_i, m_we_i, m_addr_i, m_be_i, m_wdata_i, m_rready_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
        output s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o, s_rready_o,
        input  s_gnt_i, s_rvalid_i, s_rdata_i, s_err_i
    );

    modport master (
        output m_req_i, m_we_i, m_addr_i, m_be_i, m_wdata_i, m_rready_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
        input  s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o, s_rready_o,
        output s_gnt_i, s_rvalid_i, s_rdata_i, s_err_i
    );
endinterface

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI subordinate between NUM_REQ managers,
// one transaction in flight, response routed back to the owning manager only.
module obi_rr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_W      = $clog2(NUM_REQ)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    obi_rr_arbiter_if.slave  bus,
    output logic             busy_o,
    output logic [IDX_W-1:0] owner_o
);
    localparam int unsigned BE_W = DATA_WIDTH / 8;
    localparam int unsigned IW1  = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
    logic [BE_W-1:0]       be_a    [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDX_W:0]       off;
    logic [IDX_W:0]       sum;
    logic [IDX_W-1:0]     winner;
    logic                 any_req;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = bus.m_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign be_a[g]    = bus.m_be_i[g*BE_W +: BE_W];
        assign wdata_a[g] = bus.m_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Rotate requests so that ptr_q lands at bit 0, take the first set bit, rotate back.
    always_comb begin
        req_dbl = {bus.m_req_i, bus.m_req_i};
        req_rot = NUM_REQ'(req_dbl >> ptr_q);
        any_req = 1'b0;
        off     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_req && req_rot[i]) begin
                any_req = 1'b1;
                off     = IW1'(i);
            end
        end
        sum = {1'b0, ptr_q} + off;
        if (sum >= IW1'(NUM_REQ)) begin
            sum = sum - IW1'(NUM_REQ);
        end
        winner = sum[IDX_W-1:0];
    end

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        ptr_d          = ptr_q;
        bus.m_gnt_o    = '0;
        bus.m_rvalid_o = '0;
        bus.m_rdata_o  = '0;
        bus.m_err_o    = 1'b0;
        bus.s_req_o    = 1'b0;
        bus.s_we_o     = 1'b0;
        bus.s_addr_o   = '0;
        bus.s_be_o     = '0;
        bus.s_wdata_o  = '0;
        bus.s_rready_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    sel_d   = winner;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                bus.s_req_o        = bus.m_req_i[sel_q];
                bus.s_we_o         = bus.m_we_i[sel_q];
                bus.s_addr_o       = addr_a[sel_q];
                bus.s_be_o         = be_a[sel_q];
                bus.s_wdata_o      = wdata_a[sel_q];
                bus.m_gnt_o[sel_q] = bus.s_gnt_i;
                // A manager withdrawing its request before grant abandons the slot.
                if (!bus.m_req_i[sel_q]) begin
                    state_d = IDLE;
                end else if (bus.s_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.s_rready_o        = bus.m_rready_i[sel_q];
                bus.m_rvalid_o[sel_q] = bus.s_rvalid_i;
                bus.m_rdata_o         = bus.s_rdata_i;
                bus.m_err_o           = bus.s_err_i;
                if (bus.s_rvalid_i && bus.m_rready_i[sel_q]) begin
                    state_d = IDLE;
                    ptr_d   = (sel_q == IDX_W'(NUM_REQ - 1)) ? '0 : sel_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign owner_o = busy_o ? sel_q : '0;

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Randomized self-checking bench for obi_rr_arbiter against a transaction-level
// round-robin model; the bench plays both the managers and the subordinate.
module tb_obi_rr_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    logic       clk;
    logic       reset_i;
    logic       busy_o;
    logic [1:0] owner_o;

    obi_rr_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    obi_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus),
        .busy_o  (busy_o),
        .owner_o (owner_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ptr_m    = 0;

    logic [AW-1:0] addr_a  [N];
    logic [DW-1:0] wdata_a [N];
    logic [BW-1:0] be_a    [N];
    logic [N-1:0]  we_a;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Round-robin rule: first requester at or after ptr, searching upward mod N.
    function automatic int rr_winner(input int ptr, input logic [N-1:0] rq);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (((rq >> j) & 4'd1) != 4'd0) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int w);
        return 4'(1 << w);
    endfunction

    task automatic load_managers();
        for (int i = 0; i < N; i++) begin
            addr_a[i]  = $urandom;
            wdata_a[i] = $urandom;
            be_a[i]    = 4'($urandom);
        end
        we_a          = 4'($urandom);
        bus.m_addr_i  = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};
        bus.m_wdata_i = {wdata_a[3], wdata_a[2], wdata_a[1], wdata_a[0]};
        bus.m_be_i    = {be_a[3], be_a[2], be_a[1], be_a[0]};
        bus.m_we_i    = we_a;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".busy"},   64'(busy_o), 64'd0);
        chk({tag, ".owner"},  64'(owner_o), 64'd0);
        chk({tag, ".m_gnt"},  64'(bus.m_gnt_o), 64'd0);
        chk({tag, ".m_rvld"}, 64'(bus.m_rvalid_o), 64'd0);
        chk({tag, ".m_rdat"}, 64'(bus.m_rdata_o), 64'd0);
        chk({tag, ".m_err"},  64'(bus.m_err_o), 64'd0);
        chk({tag, ".s_req"},  64'(bus.s_req_o), 64'd0);
        chk({tag, ".s_we"},   64'(bus.s_we_o), 64'd0);
        chk({tag, ".s_addr"}, 64'(bus.s_addr_o), 64'd0);
        chk({tag, ".s_be"},   64'(bus.s_be_o), 64'd0);
        chk({tag, ".s_wdat"}, 64'(bus.s_wdata_o), 64'd0);
        chk({tag, ".s_rrdy"}, 64'(bus.s_rready_o), 64'd0);
    endtask

    // One arbitration cycle with stray subordinate activity that must be ignored.
    task automatic idle_cycle(input logic [N-1:0] rq, output int w);
        @(negedge clk);
        load_managers();
        bus.m_req_i    = rq;
        bus.m_rready_i = 4'($urandom);
        bus.s_gnt_i    = 1'($urandom);
        bus.s_rvalid_i = 1'($urandom);
        bus.s_rdata_i  = $urandom;
        bus.s_err_i    = 1'($urandom);
        #1;
        check_idle("idle");
        w = rr_winner(ptr_m, rq);
    endtask

    task automatic addr_cycle(input int w, input logic gnt, input logic keep);
        @(negedge clk);
        bus.m_req_i    = keep ? (4'($urandom) | onehot(w)) : (4'($urandom) & ~onehot(w));
        bus.s_gnt_i    = gnt;
        bus.m_rready_i = 4'hF;
        bus.s_rvalid_i = 1'($urandom);
        bus.s_rdata_i  = $urandom;
        #1;
        chk("addr.busy",   64'(busy_o), 64'd1);
        chk("addr.owner",  64'(owner_o), 64'(w));
        chk("addr.s_req",  64'(bus.s_req_o), 64'(keep));
        chk("addr.s_addr", 64'(bus.s_addr_o), 64'(addr_a[w]));
        chk("addr.s_wdat", 64'(bus.s_wdata_o), 64'(wdata_a[w]));
        chk("addr.s_be",   64'(bus.s_be_o), 64'(be_a[w]));
        chk("addr.s_we",   64'(bus.s_we_o), 64'(we_a[w]));
        chk("addr.m_gnt",  64'(bus.m_gnt_o), gnt ? 64'(onehot(w)) : 64'd0);
        chk("addr.m_rvld", 64'(bus.m_rvalid_o), 64'd0);
        chk("addr.s_rrdy", 64'(bus.s_rready_o), 64'd0);
    endtask

    task automatic run_txn(input logic [N-1:0] rq, input int gd, input int vd,
                           input int rs, input logic err);
        int w;
        int last;
        logic [N-1:0] rr;
        logic vld;
        idle_cycle(rq, w);
        for (int k = 0; k <= gd; k++) addr_cycle(w, k == gd, 1'b1);
        last = vd + rs;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            vld = (k >= vd);
            rr  = 4'($urandom);
            if (k >= vd && k < last) rr = rr & ~onehot(w);
            if (k == last) rr = rr | onehot(w);
            bus.m_rready_i = rr;
            bus.m_req_i    = 4'($urandom);
            bus.s_gnt_i    = 1'($urandom);
            bus.s_rvalid_i = vld;
            bus.s_rdata_i  = $urandom;
            bus.s_err_i    = (k == last) ? err : 1'($urandom);
            #1;
            chk("resp.busy",   64'(busy_o), 64'd1);
            chk("resp.owner",  64'(owner_o), 64'(w));
            chk("resp.s_req",  64'(bus.s_req_o), 64'd0);
            chk("resp.m_gnt",  64'(bus.m_gnt_o), 64'd0);
            chk("resp.s_rrdy", 64'(bus.s_rready_o), 64'(rr[w]));
            chk("resp.m_rvld", 64'(bus.m_rvalid_o), vld ? 64'(onehot(w)) : 64'd0);
            chk("resp.m_rdat", 64'(bus.m_rdata_o), 64'(bus.s_rdata_i));
            chk("resp.m_err",  64'(bus.m_err_o), 64'(bus.s_err_i));
        end
        ptr_m = (w + 1) % N;
    endtask

    // Winner withdraws its request before grant; pointer must not advance.
    task automatic run_abort(input logic [N-1:0] rq, input int n);
        int w;
        idle_cycle(rq, w);
        for (int k = 0; k < n; k++) addr_cycle(w, 1'b0, 1'b1);
        addr_cycle(w, 1'b0, 1'b0);
    endtask

    task automatic run_reset_mid();
        int w;
        idle_cycle(4'b0010, w);
        addr_cycle(w, 1'b1, 1'b1);
        @(negedge clk);
        bus.s_rvalid_i = 1'b0;
        reset_i        = 1'b1;
        #1;
        chk("rst.resp_busy", 64'(busy_o), 64'd1);
        @(negedge clk);
        reset_i        = 1'b0;
        bus.m_req_i    = '0;
        bus.s_gnt_i    = 1'b1;
        bus.s_rvalid_i = 1'b1;
        bus.s_rdata_i  = $urandom;
        bus.s_err_i    = 1'b1;
        #1;
        check_idle("rst");
        ptr_m = 0;
    endtask

    initial begin
        reset_i        = 1'b1;
        bus.m_req_i    = '0;
        bus.m_we_i     = '0;
        bus.m_addr_i   = '0;
        bus.m_be_i     = '0;
        bus.m_wdata_i  = '0;
        bus.m_rready_i = '0;
        bus.s_gnt_i    = 1'b0;
        bus.s_rvalid_i = 1'b0;
        bus.s_rdata_i  = '0;
        bus.s_err_i    = 1'b0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        #1;
        check_idle("reset");

        run_txn(4'b0001, 0, 1, 0, 1'b0);
        for (int i = 0; i < 5; i++) run_txn(4'b1111, 0, 0, 0, 1'b0);
        run_txn(4'b0100, 0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) run_txn(4'b0101, 0, 0, 0, 1'b0);
        run_txn(4'b0100, 3, 0, 0, 1'b0);
        run_txn(4'b0010, 0, 0, 2, 1'b1);
        run_abort(4'b1000, 2);
        run_txn(4'b1111, 0, 0, 0, 1'b0);
        run_reset_mid();
        run_txn(4'b1111, 0, 0, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [N-1:0] rq;
            rq = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 7) == 0) begin
                run_abort(rq, $urandom_range(0, 2));
            end else begin
                run_txn(rq, $urandom_range(0, 3), $urandom_range(0, 2),
                        $urandom_range(0, 2), 1'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
